program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, packs bytes into big-endian 32-bit MIPS words, and writes them sequentially into the instruction memory write port. It holds the pipelined CPU in reset while loading and releases it once the programmed word count has been written. It sits beside the CPU top level, between a host byte source (UART receiver or testbench) and instruction memory.

## Interface

Parameters:
- ADDR_WIDTH, 8, word-address bits; capacity 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0, byte address of the first word written.
- TIMEOUT, 1000000, idle cycles allowed between bytes during LOAD before abort; must be ≥1.

Ports:
- CLK_IN  in  1  single clock; all state updates on its rising edge.
- GLOBALRESET  in  1  synchronous, active-high reset.
- start_in  in  1  start request; sampled only in IDLE or DONE.
- len_in  in  ADDR_WIDTH+1  number of words to load; sampled with start_in.
- byte_in  in  8  stream byte.
- byte_valid_in  in  1  byte_in is valid.
- byte_ready_out  out  1  loader can accept a byte.
- mem_addr_out  out  32  byte address of the write.
- mem_data_out  out  32  packed word.
- mem_wr_out  out  1  one-cycle write strobe to instruction memory.
- cpu_reset_out  out  1  reset to the CPU; high holds the CPU.
- busy_out  out  1  high in LOAD or WRITE.
- done_out  out  1  high in DONE.
- err_out  out  1  sticky timeout flag; cleared by an accepted start.

## Operation

- States: IDLE, LOAD, WRITE, DONE.
- IDLE: cpu_reset_out=1, byte_ready_out=0. On start_in: if len_in=0, go to DONE; if len_in > 2**ADDR_WIDTH, set err_out and stay in IDLE; otherwise latch len_in, clear word index, byte index and err_out, then go to LOAD.
- LOAD: byte_ready_out=1. A byte is accepted when byte_valid_in && byte_ready_out at a rising edge.
  - Byte k (0..3) of a word goes into bits [31-8k:24-8k], so the first byte is the MSB.
  - Accepting byte 3 goes to WRITE.
- WRITE: lasts one cycle.
  - mem_wr_out=1, byte_ready_out=0.
  - mem_addr_out = BASE_ADDR + 4*word_index (32-bit, wrap modulo 2**32).
  - mem_data_out = the packed word.
  - Next state: DONE if word_index+1 == len, else increment word_index and return to LOAD.
- DONE: cpu_reset_out=0, done_out=1. start_in restarts exactly as from IDLE, and cpu_reset_out reasserts in the next cycle.
- Timeout: the idle counter resets on every accepted byte and on entry to LOAD. It increments each LOAD cycle with no accepted byte. When it reaches TIMEOUT: set err_out, discard the partial word, go to IDLE. Words already written stay in memory.
- start_in in LOAD or WRITE is ignored.
- Bytes offered outside LOAD are not accepted, because byte_ready_out=0.

## Timing

- Reset values:
  - state=IDLE, cpu_reset_out=1.
  - byte_ready_out, mem_wr_out, busy_out, done_out, err_out = 0.
  - mem_addr_out, mem_data_out = 0.
- Start-to-ready latency: start_in sampled at edge N; byte_ready_out is high in cycle N+1.
- Write latency: the 4th byte is accepted at edge M; mem_wr_out is high in cycle M+1 only.
- Peak throughput: one word per 5 cycles, i.e. 4 accept cycles plus 1 WRITE.
- After the final write, done_out=1 and cpu_reset_out=0 in the cycle after the WRITE cycle.
- mem_addr_out and mem_data_out are registered. They hold their last value outside WRITE and change only on the transition into WRITE.
- GLOBALRESET asserted at any edge overrides everything, mid-word or mid-write. Outputs take their reset values from the next cycle. Memory contents are untouched.
- Full capacity: len_in = 2**ADDR_WIDTH is legal. word_index must not overflow before the final compare.

## Structure

- Shared package program_loader_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, DONE);
  - the byte-index width (2 bits);
  - the BYTES_PER_WORD=4 constant.
- One sub-module, byte_packer: shift-in register plus 2-bit byte counter, with a clear input and a word_full output.
- The FSM, word counter and timeout counter live in program_loader.
- The instruction memory gains a synchronous write port (addr, data, write enable) driven by mem_addr_out, mem_data_out and mem_wr_out.

## Test plan

- Basic load: len=2, bytes 20 08 00 05 3C 01 00 10 back-to-back.
  - Writes 32'h20080005 @0x0, then 32'h3C010010 @0x4.
  - done_out=1 and cpu_reset_out=0 one cycle after the second write.
- Gaps and zero length:
  - len=1 with byte_valid_in toggling every other cycle produces one write, with data correct and independent of gaps.
  - start_in with len=0 goes straight to DONE and never strobes mem_wr_out.
- Timeout: TIMEOUT=10, len=2, only 6 bytes sent.
  - First word written; err_out=1 exactly 10 idle LOAD cycles after byte 6.
  - State returns to IDLE; cpu_reset_out stays 1.
- Reset mid-word: GLOBALRESET after 2 bytes of word 1, then a fresh start with len=1.
  - No spurious write occurs.
  - The new word is written @BASE_ADDR with its MSB from the first new byte.
- Busy and restart:
  - start_in pulsed during LOAD is ignored; the word count is unchanged.
  - start_in in DONE reasserts cpu_reset_out next cycle and reloads from BASE_ADDR.
- Capacity: ADDR_WIDTH=2, len=4 writes addresses 0x0, 0x4, 0x8, 0xC, then reaches DONE; len=5 sets err_out and stays in IDLE.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTE_IDX_W     = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Shift-in register that assembles four stream bytes into a big-endian word.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0]           shreg;
  logic [BYTE_IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
    end else if (shift_en) begin
      idx <= idx + BYTE_IDX_W'(1);
    end
    if (shift_en) begin
      shreg <= {shreg[15:0], byte_data};
    end
  end

  // The word is presented in the same cycle its last byte arrives, so the
  // caller can register it on the edge that accepts that byte.
  assign word      = {shreg, byte_data};
  assign word_full = shift_en && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory as 32-bit words, holding the CPU in reset until done.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          TIMEOUT    = 1000000
) (
  input  logic                  CLK_IN,
  input  logic                  GLOBALRESET,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH:0]   len_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  output logic [31:0]           mem_addr_out,
  output logic [31:0]           mem_data_out,
  output logic                  mem_wr_out,
  output logic                  cpu_reset_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state, state_next;
  logic [ADDR_WIDTH:0] len_q, word_idx, word_next;
  logic [31:0]         idle_cnt;
  logic [31:0]         packed_word;
  logic                accept, word_full, timeout, last_word;
  logic                start_ok, start_bad;

  assign accept    = (state == LOAD) && byte_valid_in;
  assign timeout   = (state == LOAD) && !byte_valid_in && (idle_cnt == 32'(TIMEOUT - 1));
  // word_idx is one bit wider than the address so a full-capacity load can
  // still compare against len without wrapping.
  assign word_next = word_idx + ONE;
  assign last_word = (word_next == len_q);

  byte_packer u_packer (
    .clk       (CLK_IN),
    .rst       (GLOBALRESET),
    .clear     (start_ok || timeout),
    .shift_en  (accept),
    .byte_data (byte_in),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_in) begin
          if (len_in == '0) begin
            state_next = DONE;
          end else if (len_in > CAPACITY) begin
            state_next = IDLE;
            start_bad  = 1'b1;
          end else begin
            state_next = LOAD;
            start_ok   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (timeout) begin
          state_next = IDLE;
        end else if (word_full) begin
          state_next = WRITE;
        end
      end
      WRITE:   state_next = last_word ? DONE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (GLOBALRESET) begin
      state        <= IDLE;
      err_out      <= 1'b0;
      len_q        <= '0;
      word_idx     <= '0;
      idle_cnt     <= '0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        len_q    <= len_in;
        word_idx <= '0;
        err_out  <= 1'b0;
      end
      if (start_bad || timeout) begin
        err_out <= 1'b1;
      end
      // Outside LOAD the counter sits at zero, which covers the reset on entry.
      if (state != LOAD || accept) begin
        idle_cnt <= '0;
      end else if (!timeout) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if (state == WRITE && !last_word) begin
        word_idx <= word_next;
      end
      if (word_full) begin
        mem_addr_out <= BASE_ADDR + (32'(word_idx) << 2);
        mem_data_out <= packed_word;
      end
    end
  end

  assign byte_ready_out = (state == LOAD);
  assign mem_wr_out     = (state == WRITE);
  assign cpu_reset_out  = (state != DONE);
  assign busy_out       = (state == LOAD) || (state == WRITE);
  assign done_out       = (state == DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one default-size instance and one tiny-capacity instance.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  len;
  logic [7:0]  bdata;
  logic        bvalid;
  logic        ready, wr, cpu_rst, busy, done, err;
  logic [31:0] addr, data;

  logic        b_start;
  logic [2:0]  b_len;
  logic [7:0]  b_bdata;
  logic        b_bvalid;
  logic        b_ready, b_wr, b_cpu_rst, b_busy, b_done, b_err;
  logic [31:0] b_addr, b_data;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .TIMEOUT(10)) dut (
    .CLK_IN(clk), .GLOBALRESET(rst), .start_in(start), .len_in(len),
    .byte_in(bdata), .byte_valid_in(bvalid), .byte_ready_out(ready),
    .mem_addr_out(addr), .mem_data_out(data), .mem_wr_out(wr),
    .cpu_reset_out(cpu_rst), .busy_out(busy), .done_out(done), .err_out(err)
  );

  program_loader #(.ADDR_WIDTH(2), .BASE_ADDR(32'h0), .TIMEOUT(10)) dut_small (
    .CLK_IN(clk), .GLOBALRESET(rst), .start_in(b_start), .len_in(b_len),
    .byte_in(b_bdata), .byte_valid_in(b_bvalid), .byte_ready_out(b_ready),
    .mem_addr_out(b_addr), .mem_data_out(b_data), .mem_wr_out(b_wr),
    .cpu_reset_out(b_cpu_rst), .busy_out(b_busy), .done_out(b_done), .err_out(b_err)
  );

  always @(negedge clk) begin
    if (wr) wr_cnt = wr_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bdata  = b;
    bvalid = 1'b1;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL send_wait byte=%h ready never rose", b);
    end
    tick();
  endtask

  task automatic send_b(input logic [7:0] b);
    int n = 0;
    b_bdata  = b;
    b_bvalid = 1'b1;
    while (!b_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL send_b_wait byte=%h ready never rose", b);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bvalid = 1'b0; b_start = 1'b0; b_bvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_load(input logic [8:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; bdata = '0; bvalid = 1'b0;
    b_start = 1'b0; b_len = '0; b_bdata = '0; b_bvalid = 1'b0;
    tick();
    tick();
    checks++;
    if ({cpu_rst, ready, wr, busy, done, err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100000", {cpu_rst, ready, wr, busy, done, err});
    end
    checks++;
    if (addr !== 32'h0 || data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got addr=%h data=%h exp 0/0", addr, data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int base;
    start_load(9'd2);
    checks++;
    if ({ready, busy, cpu_rst} !== 3'b111) begin
      failures++;
      $display("FAIL start_to_ready got ready/busy/cpu_rst=%b exp=111", {ready, busy, cpu_rst});
    end
    base = wr_cnt;
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    checks++;
    if (wr !== 1'b1 || ready !== 1'b0 || addr !== 32'h0 || data !== 32'h20080005) begin
      failures++;
      $display("FAIL basic_word0 got wr=%b rdy=%b addr=%h data=%h exp 1 0 00000000 20080005",
               wr, ready, addr, data);
    end
    send(8'h3C); send(8'h01); send(8'h00); send(8'h10);
    checks++;
    if (wr !== 1'b1 || addr !== 32'h4 || data !== 32'h3C010010) begin
      failures++;
      $display("FAIL basic_word1 got wr=%b addr=%h data=%h exp 1 00000004 3c010010", wr, addr, data);
    end
    bvalid = 1'b0;
    tick();
    checks++;
    if ({done, cpu_rst, wr} !== 3'b100 || wr_cnt - base != 2) begin
      failures++;
      $display("FAIL basic_done got done/cpu_rst/wr=%b writes=%0d exp 100 2",
               {done, cpu_rst, wr}, wr_cnt - base);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] seq [4];
    int base;
    seq[0] = 8'hDE; seq[1] = 8'hAD; seq[2] = 8'hBE; seq[3] = 8'hEF;
    start_load(9'd1);
    base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      bvalid = 1'b0;
      tick();
      send(seq[i]);
    end
    checks++;
    if (wr !== 1'b1 || addr !== 32'h0 || data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL gaps_word got wr=%b addr=%h data=%h exp 1 00000000 deadbeef", wr, addr, data);
    end
    bvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || wr !== 1'b0 || data !== 32'hDEADBEEF || wr_cnt - base != 1) begin
      failures++;
      $display("FAIL gaps_hold got done=%b wr=%b data=%h writes=%0d exp 1 0 deadbeef 1",
               done, wr, data, wr_cnt - base);
    end
  endtask

  task automatic test_zero_len();
    int base;
    do_reset();
    base = wr_cnt;
    start_load(9'd0);
    checks++;
    if ({done, cpu_rst, busy} !== 3'b100) begin
      failures++;
      $display("FAIL zero_len_done got done/cpu_rst/busy=%b exp=100", {done, cpu_rst, busy});
    end
    repeat (3) tick();
    checks++;
    if (wr_cnt != base) begin
      failures++;
      $display("FAIL zero_len_nowrite got writes=%0d exp=0", wr_cnt - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    start_load(9'd2);
    base = wr_cnt;
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    send(8'hE5); send(8'hF6);
    bvalid = 1'b0;
    repeat (9) tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got err=%b busy=%b exp 0 1 after 9 idle", err, busy);
    end
    tick();
    checks++;
    if ({err, busy, cpu_rst, done} !== 4'b1010) begin
      failures++;
      $display("FAIL timeout_fire got err/busy/cpu_rst/done=%b exp=1010", {err, busy, cpu_rst, done});
    end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || wr_cnt - base != 1 || data !== 32'hA1B2C3D4) begin
      failures++;
      $display("FAIL timeout_sticky got err=%b busy=%b writes=%0d data=%h exp 1 0 1 a1b2c3d4",
               err, busy, wr_cnt - base, data);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    start_load(9'd1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_clears_err got err=%b busy=%b exp 0 1", err, busy);
    end
    base = wr_cnt;
    send(8'h11); send(8'h22);
    bvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, cpu_rst, ready, wr} !== 4'b0100 || wr_cnt != base) begin
      failures++;
      $display("FAIL reset_mid_state got busy/cpu_rst/rdy/wr=%b writes=%0d exp 0100 0",
               {busy, cpu_rst, ready, wr}, wr_cnt - base);
    end
    start_load(9'd1);
    send(8'h44); send(8'h55); send(8'h66); send(8'h77);
    checks++;
    if (wr !== 1'b1 || addr !== 32'h0 || data !== 32'h44556677) begin
      failures++;
      $display("FAIL reset_mid_word got wr=%b addr=%h data=%h exp 1 00000000 44556677", wr, addr, data);
    end
    bvalid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || wr_cnt - base != 1) begin
      failures++;
      $display("FAIL reset_mid_count got done=%b writes=%0d exp 1 1", done, wr_cnt - base);
    end
  endtask

  task automatic test_busy_restart();
    int base;
    do_reset();
    start_load(9'd2);
    base = wr_cnt;
    send(8'h01); send(8'h02);
    bvalid = 1'b0;
    start  = 1'b1;
    len    = 9'd1;
    tick();
    start  = 1'b0;
    send(8'h03); send(8'h04);
    checks++;
    if (wr !== 1'b1 || addr !== 32'h0 || data !== 32'h01020304) begin
      failures++;
      $display("FAIL busy_word0 got wr=%b addr=%h data=%h exp 1 00000000 01020304", wr, addr, data);
    end
    bvalid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_ignored got done=%b busy=%b exp 0 1", done, busy);
    end
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    checks++;
    if (wr !== 1'b1 || addr !== 32'h4 || data !== 32'h05060708) begin
      failures++;
      $display("FAIL busy_word1 got wr=%b addr=%h data=%h exp 1 00000004 05060708", wr, addr, data);
    end
    bvalid = 1'b0;
    tick();
    start_load(9'd1);
    checks++;
    if ({cpu_rst, busy, done} !== 3'b110) begin
      failures++;
      $display("FAIL restart_reassert got cpu_rst/busy/done=%b exp=110", {cpu_rst, busy, done});
    end
    send(8'h09); send(8'h0A); send(8'h0B); send(8'h0C);
    checks++;
    if (wr !== 1'b1 || addr !== 32'h0 || data !== 32'h090A0B0C) begin
      failures++;
      $display("FAIL restart_word got wr=%b addr=%h data=%h exp 1 00000000 090a0b0c", wr, addr, data);
    end
    bvalid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || wr_cnt - base != 3) begin
      failures++;
      $display("FAIL restart_done got done=%b writes=%0d exp 1 3", done, wr_cnt - base);
    end
  endtask

  task automatic test_capacity();
    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8; exp_addr[3] = 32'hC;
    exp_data[0] = 32'h00010203; exp_data[1] = 32'h10111213;
    exp_data[2] = 32'h20212223; exp_data[3] = 32'h30313233;
    do_reset();
    b_start = 1'b1;
    b_len   = 3'd4;
    tick();
    b_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) send_b(8'(w * 16 + k));
      checks++;
      if (b_wr !== 1'b1 || b_addr !== exp_addr[w] || b_data !== exp_data[w]) begin
        failures++;
        $display("FAIL cap_word%0d got wr=%b addr=%h data=%h exp 1 %h %h",
                 w, b_wr, b_addr, b_data, exp_addr[w], exp_data[w]);
      end
    end
    b_bvalid = 1'b0;
    tick();
    checks++;
    if ({b_done, b_cpu_rst, b_busy} !== 3'b100) begin
      failures++;
      $display("FAIL cap_done got done/cpu_rst/busy=%b exp=100", {b_done, b_cpu_rst, b_busy});
    end
    b_start = 1'b1;
    b_len   = 3'd5;
    tick();
    b_start = 1'b0;
    tick();
    checks++;
    if ({b_err, b_busy, b_done, b_cpu_rst, b_ready} !== 5'b10010) begin
      failures++;
      $display("FAIL cap_overflow got err/busy/done/cpu_rst/rdy=%b exp=10010",
               {b_err, b_busy, b_done, b_cpu_rst, b_ready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_busy_restart();
    test_capacity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
